// File: rtl/ulpi_cmd_queue_if.sv
// ulpi_cmd_queue_if: upstream command handshake and link command handshake
// of the ULPI gateway command queue, bundled for port connection.
//
// Handshake semantics:
//   upstream: a word moves from in_cmd into the queue on every rising clk edge
//     where in_valid && in_ready. in_valid/in_cmd may change freely while
//     in_ready is low; in_ready never depends on in_valid.
//   link: cmd_strobe is a one-cycle pulse and cmd holds the issued word until
//     the next issue. The link answers by raising cmd_busy while it works on
//     the command and lowering it when done.
interface ulpi_cmd_queue_if #(
  parameter int CMD_W = 8
);
  logic [CMD_W-1:0] in_cmd;
  logic             in_valid;
  logic             in_ready;
  logic [CMD_W-1:0] cmd;
  logic             cmd_strobe;
  logic             cmd_busy;

  // master: the environment (command sources plus the link block)
  modport master (
    output in_cmd, in_valid, cmd_busy,
    input  in_ready, cmd, cmd_strobe
  );

  // slave: the queue itself
  modport slave (
    input  in_cmd, in_valid, cmd_busy,
    output in_ready, cmd, cmd_strobe
  );
endinterface

// File: rtl/ulpi_cmd_queue.sv
// ulpi_cmd_queue: circular command buffer in front of the ULPI link.
// Commands are popped one at a time, strobed to the link, and tracked through
// acknowledge (cmd_busy rising) and completion (cmd_busy falling). A missing
// acknowledge is bounded by ACK_TIMEOUT cycles and reported on err_timeout.
// Optional feature macro: ULPI_CMD_QUEUE_STATS_EN enables the 16-bit
// issued-command counter on cmd_count; without it cmd_count is tied to 0.
module ulpi_cmd_queue #(
  parameter int DEPTH       = 4,
  parameter int CMD_W       = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  ulpi_cmd_queue_if.slave        bus,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] level,
  output logic                   idle,
  output logic                   err_timeout,
  output logic [15:0]            cmd_count,
  output logic [1:0]             state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Reject parameter sets the pointer arithmetic cannot handle.
  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ulpi_cmd_queue: DEPTH must be a power of two in 2..64");
  end
  if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_timeout
    $error("ulpi_cmd_queue: ACK_TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [CMD_W-1:0] cmd_q;
  logic [7:0]       tmo_q;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             load_tmo;
  logic             tmo_hit;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Occupancy follows directly from the registered pointers, so it moves on
  // the edge that performs the push, pop or flush.
  assign level = wr_ptr_q - rd_ptr_q;

  // A flush cycle refuses new words so the flush leaves the queue truly empty.
  assign bus.in_ready = !reset && !full && !flush;
  assign push         = bus.in_valid && bus.in_ready;

  // Next-state and issue control; flush takes priority over an IDLE pop.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    load_tmo = 1'b0;
    tmo_hit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty && !flush) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // busy is not looked at here; the link only answers after the strobe
        load_tmo = 1'b1;
        state_d  = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (bus.cmd_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_q == 8'd0) begin
          // command counts as issued; it is dropped, not retried
          tmo_hit = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.cmd_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Acknowledge timeout: loaded leaving ISSUE, counts down while waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= 8'd0;
    end else if (load_tmo) begin
      tmo_q <= 8'(ACK_TIMEOUT);
    end else if (state_q == ST_WAIT_ACK && tmo_q != 8'd0) begin
      tmo_q <= tmo_q - 8'd1;
    end
  end

  // Queue pointers; a flush drops every unissued entry in one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (flush) begin
        rd_ptr_q <= wr_ptr_q;
      end else if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // Queue storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.in_cmd;
    end
  end

  // Issued command word, held until the next pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q <= '0;
    end else if (pop) begin
      cmd_q <= mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  assign bus.cmd        = cmd_q;
  assign bus.cmd_strobe = (state_q == ST_ISSUE);
  assign idle           = empty && (state_q == ST_IDLE);
  assign err_timeout    = tmo_hit;
  assign state_dbg      = state_q;

`ifdef ULPI_CMD_QUEUE_STATS_EN
  logic [15:0] cnt_q;

  // One count per issue; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else if (pop) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cmd_count = cnt_q;
`else
  assign cmd_count = 16'd0;
`endif

endmodule
